// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential I-side reads into an in-order prefetch queue, handed to decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_discarded counters.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  output logic [3:0]  imem_wmask,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t          DEPTH_P   = ptr_t'(DEPTH);
  localparam logic [CW-1:0] MAX_INF_P = CW'(MAX_INFLIGHT);

  logic [31:0] pc_q, pc_d;
  ptr_t        head_q, head_d;
  ptr_t        fill_q, fill_d;
  ptr_t        tail_q, tail_d;
  ptr_t        drop_cnt_q, drop_cnt_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] slot_pc_q   [DEPTH];
  logic [31:0] slot_pc_d   [DEPTH];
  logic [31:0] slot_inst_q [DEPTH];
  logic [31:0] slot_inst_d [DEPTH];

  ptr_t          occupied;
  ptr_t          pending;
  logic [CW-1:0] inflight;
  logic          can_issue;
  logic          deq;
  logic          resp_drop;
  logic          resp_fill;
  logic          resp_err;

  // Discarded reads still occupy memory bandwidth, so they count toward the in-flight limit.
  assign occupied  = tail_q - head_q;
  assign pending   = tail_q - fill_q;
  assign inflight  = CW'(pending) + CW'(drop_cnt_q);
  assign can_issue = rst_n && (occupied < DEPTH_P) && (inflight < MAX_INF_P) && !redirect_valid;

  assign inst_valid = (head_q != fill_q);
  assign inst       = slot_inst_q[head_q[IW-1:0]];
  assign inst_pc    = slot_pc_q[head_q[IW-1:0]];
  assign deq        = inst_valid && inst_ready;

  assign resp_drop = imem_resp && (drop_cnt_q != '0);
  assign resp_fill = imem_resp && (drop_cnt_q == '0) && (fill_q != tail_q);
  assign resp_err  = imem_resp && (drop_cnt_q == '0) && (fill_q == tail_q);

  assign imem_rmask = can_issue ? 4'hF : 4'h0;
  assign imem_addr  = pc_q;
  assign imem_wmask = 4'h0;
  assign imem_wdata = 32'h0;
  assign fetch_err  = fetch_err_q;

  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    fill_d      = fill_q;
    tail_d      = tail_q;
    drop_cnt_d  = drop_cnt_q;
    fetch_err_d = fetch_err_q;
    slot_pc_d   = slot_pc_q;
    slot_inst_d = slot_inst_q;

    if (deq) head_d = head_q + ptr_t'(1);
    if (resp_drop) drop_cnt_d = drop_cnt_q - ptr_t'(1);
    if (resp_fill) begin
      slot_inst_d[fill_q[IW-1:0]] = imem_rdata;
      fill_d = fill_q + ptr_t'(1);
    end
    if (resp_err) fetch_err_d = 1'b1;

    // Reads still outstanding at the flush become drops, net of a response landing this cycle.
    if (redirect_valid) begin
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      drop_cnt_d = drop_cnt_q + pending - ptr_t'(resp_fill) - ptr_t'(resp_drop);
      pc_d       = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) fetch_err_d = 1'b1;
    end else if (can_issue) begin
      slot_pc_d[tail_q[IW-1:0]] = pc_q;
      tail_d = tail_q + ptr_t'(1);
      pc_d   = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      head_q      <= '0;
      fill_q      <= '0;
      tail_q      <= '0;
      drop_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
      slot_pc_q   <= '{default: '0};
      slot_inst_q <= '{default: '0};
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      fill_q      <= fill_d;
      tail_q      <= tail_d;
      drop_cnt_q  <= drop_cnt_d;
      fetch_err_q <= fetch_err_d;
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_discarded_q, perf_discarded_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + (deq ? 32'd1 : 32'd0);
    perf_discarded_d = perf_discarded_q + (resp_drop ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`endif

endmodule
